// File: rtl/vector_lsu.sv
// Vector load/store unit: moves up to LANES strided 64-bit elements between the
// vector register bus and the data-memory port, one element per cycle.
module vector_lsu #(
    parameter int  ADDR_W  = 15,
    parameter int  DATA_W  = 64,
    parameter int  LANES   = 8,
    parameter int  MEM_MAX = 24576,
    localparam int VLEN_W  = $clog2(LANES + 1),
    localparam int LANE_W  = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    op_store,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [ADDR_W-1:0]       stride,
    input  logic [VLEN_W-1:0]       vlen,
    input  logic [LANES*DATA_W-1:0] store_data,
    output logic [LANES*DATA_W-1:0] load_data,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [ADDR_W-1:0]       mem_dir,
    output logic                    mem_write_flag,
    output logic [DATA_W-1:0]       mem_data_in,
    input  logic [DATA_W-1:0]       mem_data_out
);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, STORE} state_t;

    state_t                  state, state_next;
    logic [VLEN_W-1:0]       elem_cnt, issue_idx;
    logic [ADDR_W-1:0]       addr_acc, stride_reg;
    logic [LANES*DATA_W-1:0] store_shift;
    logic                    drain_cnt;
    logic                    p1_valid, p1_oor, p2_valid, p2_oor;
    logic [LANE_W-1:0]       p1_lane, p2_lane;
    logic                    accept, issue, finish, addr_oor;

    assign addr_oor = (addr_acc > ADDR_W'(MEM_MAX));
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // LOAD hands over to DRAIN once the last address is out; DRAIN waits for
    // the two-edge read pipeline to deliver the final lane.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        issue      = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = op_store ? STORE : LOAD;
                end
            end
            LOAD: begin
                if (issue_idx == elem_cnt) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end else begin
                    issue = 1'b1;
                    if (issue_idx + VLEN_W'(1) == elem_cnt) state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            STORE: begin
                if (issue_idx == elem_cnt) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end else begin
                    issue = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            elem_cnt       <= '0;
            issue_idx      <= '0;
            addr_acc       <= '0;
            stride_reg     <= '0;
            store_shift    <= '0;
            drain_cnt      <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            mem_dir        <= '0;
            mem_write_flag <= 1'b0;
            mem_data_in    <= '0;
        end else begin
            done           <= finish;
            mem_write_flag <= 1'b0;
            drain_cnt      <= (state == DRAIN);
            if (accept) begin
                elem_cnt    <= (vlen > VLEN_W'(LANES)) ? VLEN_W'(LANES) : vlen;
                issue_idx   <= '0;
                addr_acc    <= base_addr;
                stride_reg  <= stride;
                store_shift <= store_data;
                err         <= 1'b0;
            end else if (issue) begin
                issue_idx <= issue_idx + VLEN_W'(1);
                addr_acc  <= addr_acc + stride_reg;
                mem_dir   <= addr_acc;
                if (addr_oor) err <= 1'b1;
                // Out-of-range store elements still occupy their cycle, just without a write.
                if (state == STORE) begin
                    mem_write_flag <= !addr_oor;
                    mem_data_in    <= store_shift[DATA_W-1:0];
                    store_shift    <= store_shift >> DATA_W;
                end
            end
        end
    end

    // Lane tag follows each load address through the memory's registered read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_valid  <= 1'b0;
            p1_oor    <= 1'b0;
            p1_lane   <= '0;
            p2_valid  <= 1'b0;
            p2_oor    <= 1'b0;
            p2_lane   <= '0;
            load_data <= '0;
        end else begin
            p1_valid <= issue && (state == LOAD);
            p1_oor   <= addr_oor;
            p1_lane  <= issue_idx[LANE_W-1:0];
            p2_valid <= p1_valid;
            p2_oor   <= p1_oor;
            p2_lane  <= p1_lane;
            if (accept && !op_store)
                load_data <= '0;
            else if (p2_valid)
                load_data[int'(p2_lane)*DATA_W +: DATA_W] <= p2_oor ? '0 : mem_data_out;
        end
    end

endmodule

// File: tb/tb_vector_lsu.sv
// Bench for vector_lsu: a memory answers the DUT port while a behavioural
// model predicts every output on every cycle from the operation parameters.
`timescale 1ns/1ps
module tb_vector_lsu;

    localparam int ADDR_W    = 15;
    localparam int DATA_W    = 64;
    localparam int LANES     = 8;
    localparam int MEM_MAX   = 24576;
    localparam int VLEN_W    = $clog2(LANES + 1);
    localparam int MEM_WORDS = 1 << ADDR_W;
    localparam int BUS_W     = LANES * DATA_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic              op_store = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W-1:0] stride = '0;
    logic [VLEN_W-1:0] vlen = '0;
    logic [BUS_W-1:0]  store_data = '0;
    logic [BUS_W-1:0]  load_data;
    logic              busy, done, err, mem_write_flag;
    logic [ADDR_W-1:0] mem_dir;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out = '0;

    int checks = 0;
    int failures = 0;

    logic [DATA_W-1:0] tbMem  [MEM_WORDS];
    logic [DATA_W-1:0] refMem [MEM_WORDS];

    vector_lsu #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LANES(LANES), .MEM_MAX(MEM_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_store(op_store),
        .base_addr(base_addr), .stride(stride), .vlen(vlen), .store_data(store_data),
        .load_data(load_data), .busy(busy), .done(done), .err(err),
        .mem_dir(mem_dir), .mem_write_flag(mem_write_flag),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    // Data memory: registered read, write on the falling edge.
    always @(posedge clk) mem_data_out <= tbMem[mem_dir];
    always @(negedge clk) if (mem_write_flag) tbMem[mem_dir] <= mem_data_in;

    function automatic logic [DATA_W-1:0] initWord(input int a);
        logic [31:0] x;
        x = a;
        return {x * 32'h9E37_79B9, x ^ 32'h5A5A_0000};
    endfunction

    task automatic checkOutput(input string name, input logic [BUS_W-1:0] actual,
                               input logic [BUS_W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: k counts edges since the accepting edge.
    bit                active = 1'b0;
    int                k = 0, mN = 0, mFin = 0;
    bit                mOp = 1'b0;
    logic [ADDR_W-1:0] mBase = '0, mStride = '0, mA = '0;
    logic [BUS_W-1:0]  mStore = '0;
    logic              expBusy = 1'b0, expDone = 1'b0, expErr = 1'b0, expFlag = 1'b0;
    logic [ADDR_W-1:0] expDir = '0;
    logic [DATA_W-1:0] expData = '0;
    logic [BUS_W-1:0]  expLoad = '0;

    function automatic logic [ADDR_W-1:0] addrOf(input int i);
        int t;
        t = int'(mBase) + i * int'(mStride);
        return t[ADDR_W-1:0];
    endfunction

    task automatic resetModel();
        active = 1'b0; k = 0;
        expBusy = 1'b0; expDone = 1'b0; expErr = 1'b0; expFlag = 1'b0;
        expDir = '0; expData = '0; expLoad = '0;
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            resetModel();
        end else begin
            if (start && !(active && k < mFin)) begin
                active = 1'b1; k = 0;
                mOp = op_store; mBase = base_addr; mStride = stride; mStore = store_data;
                mN = (int'(vlen) > LANES) ? LANES : int'(vlen);
                mFin = (mN == 0) ? 1 : (mOp ? mN + 1 : mN + 2);
                expErr = 1'b0;
                if (!mOp) expLoad = '0;
            end else if (active && k < 1000) begin
                k++;
            end
            if (active) begin
                expBusy = (k < mFin);
                expDone = (k == mFin);
                expFlag = 1'b0;
                if (k >= 1 && k <= mN) begin
                    mA = addrOf(k - 1);
                    expDir = mA;
                    if (int'(mA) > MEM_MAX) expErr = 1'b1;
                    if (mOp) begin
                        expData = mStore[(k-1)*DATA_W +: DATA_W];
                        expFlag = (int'(mA) <= MEM_MAX);
                    end
                end
                if (!mOp && k >= 3 && k - 3 < mN) begin
                    mA = addrOf(k - 3);
                    expLoad[(k-3)*DATA_W +: DATA_W] = (int'(mA) > MEM_MAX) ? '0 : refMem[mA];
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && expFlag) refMem[expDir] = expData;
    end

    initial forever begin
        @(negedge clk);
        checkOutput("busy", busy, expBusy);
        checkOutput("done", done, expDone);
        checkOutput("err", err, expErr);
        checkOutput("mem_write_flag", mem_write_flag, expFlag);
        checkOutput("mem_dir", mem_dir, expDir);
        checkOutput("mem_data_in", mem_data_in, expData);
        checkOutput("load_data", load_data, expLoad);
    end

    // Issues one operation and measures edges from the sampling edge to done.
    task automatic applyStimulus(input bit op, input logic [ADDR_W-1:0] base,
                                 input logic [ADDR_W-1:0] st, input logic [VLEN_W-1:0] vl,
                                 input logic [BUS_W-1:0] data, input int expLat,
                                 input bit glitch);
        int lat;
        op_store = op; base_addr = base; stride = st; vlen = vl; store_data = data;
        start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        lat = 0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (glitch && e == 1) begin start = 1'b1; op_store = ~op; end
            if (glitch && e == 2) begin start = 1'b0; op_store = op; end
            if (done) begin
                lat = e;
                break;
            end
        end
        checkOutput("latency", lat, expLat);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [BUS_W-1:0] seqData, data2, rdata, expVec;
        bit               op;
        logic [ADDR_W-1:0] base, st;
        logic [VLEN_W-1:0] vl;
        int               n, lat;

        for (int a = 0; a < MEM_WORDS; a++) begin
            tbMem[a]  = initWord(a);
            refMem[a] = initWord(a);
        end
        tbMem['h100] = 64'hA; refMem['h100] = 64'hA;
        tbMem['h103] = 64'hB; refMem['h103] = 64'hB;
        tbMem['h106] = 64'hC; refMem['h106] = 64'hC;

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #2;
        checkOutput("reset_busy", busy, '0);
        checkOutput("reset_done", done, '0);
        checkOutput("reset_dir", mem_dir, '0);
        checkOutput("reset_load", load_data, '0);

        $display("[TB] sequential store and load");
        for (int i = 0; i < LANES; i++) seqData[i*DATA_W +: DATA_W] = 64'(i + 1);
        applyStimulus(1'b1, 15'h10, 15'd1, 4'd8, seqData, 9, 1'b0);
        for (int i = 0; i < LANES; i++) checkOutput("store_word", tbMem[16 + i], 64'(i + 1));
        checkOutput("store_err", err, '0);
        applyStimulus(1'b0, 15'h10, 15'd1, 4'd8, '0, 10, 1'b0);
        checkOutput("load_seq", load_data, seqData);

        $display("[TB] strided load");
        applyStimulus(1'b0, 15'h100, 15'd3, 4'd3, '0, 5, 1'b0);
        expVec = '0;
        expVec[0 +: 64] = 64'hA; expVec[64 +: 64] = 64'hB; expVec[128 +: 64] = 64'hC;
        checkOutput("load_stride", load_data, expVec);

        $display("[TB] store crossing the top of memory");
        data2 = '0;
        data2[0 +: 64] = 64'h11; data2[64 +: 64] = 64'h22; data2[128 +: 64] = 64'h33;
        applyStimulus(1'b1, 15'd24575, 15'd1, 4'd3, data2, 4, 1'b0);
        checkOutput("oor_err", err, 1);
        checkOutput("oor_w0", tbMem[24575], 64'h11);
        checkOutput("oor_w1", tbMem[24576], 64'h22);
        checkOutput("oor_w2", tbMem[24577], initWord(24577));

        $display("[TB] zero length, clamping and ignored start");
        applyStimulus(1'b0, 15'h10, 15'd1, 4'd0, '0, 1, 1'b0);
        checkOutput("vlen0_err", err, 0);
        checkOutput("vlen0_load", load_data, '0);
        applyStimulus(1'b0, 15'h10, 15'd1, 4'd12, '0, 10, 1'b1);
        checkOutput("clamp_load", load_data, seqData);

        $display("[TB] reset during store");
        for (int i = 0; i < LANES; i++) data2[i*DATA_W +: DATA_W] = {$urandom, $urandom};
        op_store = 1'b1; base_addr = 15'h200; stride = 15'd1; vlen = 4'd8;
        store_data = data2; start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_busy", busy, '0);
        checkOutput("rst_flag", mem_write_flag, '0);
        checkOutput("rst_data_in", mem_data_in, '0);
        checkOutput("rst_dir", mem_dir, '0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        checkOutput("rst_w0", tbMem['h200], data2[0 +: 64]);
        checkOutput("rst_w1", tbMem['h201], data2[64 +: 64]);
        checkOutput("rst_w2", tbMem['h202], initWord('h202));
        applyStimulus(1'b0, 15'h200, 15'd1, 4'd3, '0, 5, 1'b0);
        rdata = '0;
        rdata[0 +: 64] = data2[0 +: 64]; rdata[64 +: 64] = data2[64 +: 64];
        rdata[128 +: 64] = initWord('h202);
        checkOutput("rst_reload", load_data, rdata);

        $display("[TB] random operations");
        for (int t = 0; t < 40; t++) begin
            op = 1'($urandom_range(0, 1));
            base = ($urandom_range(0, 3) == 0) ? 15'(24570 + $urandom_range(0, 12))
                                               : 15'($urandom);
            st = ($urandom_range(0, 3) == 0) ? 15'($urandom) : 15'($urandom_range(0, 4));
            vl = 4'($urandom_range(0, 15));
            for (int i = 0; i < LANES; i++) data2[i*DATA_W +: DATA_W] = {$urandom, $urandom};
            n = (int'(vl) > LANES) ? LANES : int'(vl);
            lat = (n == 0) ? 1 : (op ? n + 1 : n + 2);
            applyStimulus(op, base, st, vl, data2, lat, (n >= 2) && ($urandom_range(0, 3) == 0));
        end

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
